// File: rtl/vedic8x8_seq.sv
// vedic8x8_seq: 8x8 unsigned multiplier that runs four nibble passes through a
// shared external 4x4 vedic core, with a per-wait timeout abort.
//
// state  | meaning
// IDLE   | waiting for start; captures operands on acceptance
// ISSUE  | nibble operands for pass k presented, mul_start raised
// WAIT   | request held until the core reports done, then accumulate
// DRAIN  | request dropped, waiting for the core done to fall
// FINISH | result, done (and error on abort) visible for one cycle
module vedic8x8_seq #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic        done,
  output logic        busy,
  output logic        error,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic        mul_start,
  input  logic [7:0]  mul_result,
  input  logic        mul_done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [7:0]    a_q;
  logic [7:0]    b_q;
  logic [15:0]   acc;
  logic [1:0]    k;
  logic [CW-1:0] cnt;

  logic          capture;
  logic          acc_en;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          k_inc;
  logic          abort;

  logic [1:0]    k_issue;
  logic [7:0]    src_a;
  logic [7:0]    src_b;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [15:0]   prod_ext;
  logic [15:0]   addend;

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    acc_en     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    k_inc      = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clr    = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          acc_en     = 1'b1;
          cnt_clr    = 1'b1;
          next_state = DRAIN;
        end else if (cnt == CNT_LAST) begin
          abort      = 1'b1;
          next_state = FINISH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (!mul_done) begin
          if (k == 2'd3) begin
            next_state = FINISH;
          end else begin
            k_inc      = 1'b1;
            next_state = ISSUE;
          end
        end else if (cnt == CNT_LAST) begin
          abort      = 1'b1;
          next_state = FINISH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operands for the pass about to be issued: bit 0 of k picks the a nibble,
  // bit 1 picks the b nibble. On acceptance the raw inputs are used directly.
  always_comb begin
    k_issue = capture ? 2'd0 : k + 2'd1;
    src_a   = capture ? a : a_q;
    src_b   = capture ? b : b_q;
    nib_a   = k_issue[0] ? src_a[7:4] : src_a[3:0];
    nib_b   = k_issue[1] ? src_b[7:4] : src_b[3:0];
  end

  always_comb begin
    prod_ext = {8'b0, mul_result};
    case (k)
      2'd0:    addend = prod_ext;
      2'd3:    addend = prod_ext << 8;
      default: addend = prod_ext << 4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      k         <= '0;
      cnt       <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
    end else begin
      if (capture) begin
        a_q <= a;
        b_q <= b;
        acc <= '0;
        k   <= '0;
      end else begin
        if (k_inc) begin
          k <= k + 2'd1;
        end
        if (acc_en) begin
          acc <= acc + addend;
        end
      end

      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CW'(1);
      end

      if (next_state == ISSUE) begin
        mul_a <= nib_a;
        mul_b <= nib_b;
      end

      // Outputs are registered from next_state so they line up with the state
      // they describe rather than trailing it by a cycle.
      mul_start <= (next_state == ISSUE) || (next_state == WAIT);
      busy      <= (next_state != IDLE);
      done      <= (next_state == FINISH);
      error     <= abort;
      if (next_state == FINISH) begin
        result <= abort ? 16'h0000 : acc;
      end
    end
  end

endmodule

// File: tb/tb_vedic8x8_seq.sv
// Scoreboard bench for vedic8x8_seq with a behavioural 4x4 core of
// programmable latency.
module tb_vedic8x8_seq;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        error;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic        mul_start;
  logic [7:0]  mul_result;
  logic        mul_done;

  vedic8x8_seq #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .error      (error),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_result (mul_result),
    .mul_done   (mul_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pair_q[$];
  int         cmp_cnt = 0;
  int         err_cnt = 0;
  int         cyc = 0;
  int         rise_cnt = 0;

  // Behavioural core: done follows mul_start delayed by lat cycles.
  logic [15:0] hist = '0;
  logic [3:0]  lat = 4'd1;
  logic [3:0]  lat_req = 4'd1;
  bit          stuck = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || !busy) begin
      hist <= '0;
      lat  <= lat_req;
    end else begin
      hist <= {hist[14:0], mul_start};
    end
  end

  assign mul_done   = !stuck && hist[lat - 4'd1];
  assign mul_result = mul_a * mul_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks the issued nibble pairs.
  logic       prev_done = 1'b0;
  logic       prev_ms = 1'b0;
  logic [7:0] prev_pair = '0;
  always @(posedge clk) begin
    exp_t e;
    logic [7:0] p;
    #1;
    if (prev_done) begin
      chk("busy_after_done", {31'b0, busy}, 32'd0);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_done: result 0x%0h error %0b with nothing pending", result, error);
      end else begin
        e = exp_q.pop_front();
        chk("result", {16'b0, result}, {16'b0, e.res});
        chk("error", {31'b0, error}, {31'b0, e.err});
        chk("done_cycle", cyc, e.due);
        chk("busy_at_done", {31'b0, busy}, 32'd1);
        chk("mul_start_at_done", {31'b0, mul_start}, 32'd0);
      end
    end
    if (mul_start && !prev_ms) begin
      rise_cnt++;
      if (pair_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_issue: mul_a %0h mul_b %0h", mul_a, mul_b);
      end else begin
        p = pair_q.pop_front();
        chk("issue_pair", {24'b0, mul_a, mul_b}, {24'b0, p});
      end
    end else if (mul_start && prev_ms) begin
      chk("operand_hold", {24'b0, mul_a, mul_b}, {24'b0, prev_pair});
    end
    prev_ms   = mul_start;
    prev_done = done;
    prev_pair = {mul_a, mul_b};
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL idle_wait: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL settle_wait: %0d results pending after %0d cycles", exp_q.size(), n);
    end
    repeat (2) @(negedge clk);
  endtask

  // Called on a negedge; start is held for exactly one sampling edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] l,
                       input bit to_abort, input bit expect_done, input int npairs,
                       input logic [15:0] exp_res);
    exp_t e;
    wait_idle();
    lat_req = l;
    a       = ia;
    b       = ib;
    start   = 1'b1;
    for (int k = 0; k < npairs; k++) begin
      pair_q.push_back({k[0] ? ia[7:4] : ia[3:0], k[1] ? ib[7:4] : ib[3:0]});
    end
    if (expect_done) begin
      e.res = to_abort ? 16'h0000 : exp_res;
      e.err = to_abort;
      e.due = to_abort ? cyc + 2 + TO : cyc + 8 * int'(l) + 9;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_result"}, {16'b0, result}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_error"}, {31'b0, error}, 32'd0);
    chk({tag, "_mul_a"}, {28'b0, mul_a}, 32'd0);
    chk({tag, "_mul_b"}, {28'b0, mul_b}, 32'd0);
    chk({tag, "_mul_start"}, {31'b0, mul_start}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          base;
    int          n;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [3:0]  rl;
    logic [15:0] rp;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full-scale operands, latency 5.
    issue(8'hFF, 8'hFF, 4'd5, 1'b0, 1'b1, 4, 16'hFE01);
    settle();

    // Back-to-back operations.
    issue(8'h0F, 8'h10, 4'd3, 1'b0, 1'b1, 4, 16'h00F0);
    issue(8'h00, 8'hA5, 4'd2, 1'b0, 1'b1, 4, 16'h0000);
    settle();

    // A start pulsed while busy must be dropped.
    issue(8'h03, 8'h05, 4'd4, 1'b0, 1'b1, 4, 16'h000F);
    repeat (3) @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    settle();

    // Core never answers: abort after TO cycles in WAIT.
    stuck = 1'b1;
    issue(8'h55, 8'h66, 4'd5, 1'b1, 1'b1, 1, 16'h0000);
    settle();
    stuck = 1'b0;

    // Reset during pass k=2 abandons the operation.
    base = rise_cnt;
    issue(8'hAB, 8'hCD, 4'd3, 1'b0, 1'b0, 3, 16'h0000);
    n = 0;
    while (rise_cnt < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL pass2_wait: saw %0d issues, required 3", rise_cnt - base);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("midop_reset");
    repeat (3) @(negedge clk);
    issue(8'hAB, 8'hCD, 4'd3, 1'b0, 1'b1, 4, 16'h88EF);
    settle();

    // Random operands and latencies.
    repeat (1000) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rl = 4'($urandom_range(1, 8));
      rp = 16'(ra) * 16'(rb);
      issue(ra, rb, rl, 1'b0, 1'b1, 4, rp);
    end
    settle();

    chk("pending_results", exp_q.size(), 32'd0);
    chk("pending_issues", pair_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
